// File: rtl/cam_pkg.sv
// Shared types and helpers for the 2PPC camera scaling path.
// Holds the row-state encoding and the pixel-replication helper.
package cam_pkg;

    typedef enum logic {
        ROW_A = 1'b0,
        ROW_B = 1'b1
    } row_state_e;

    localparam int PPC    = 2;
    localparam int MAX_PD = 16;

    // Replicate one pd-bit pixel into a two-pixel word {px, px}.
    function automatic logic [2*MAX_PD-1:0] dup_px(
        input logic [MAX_PD-1:0] px,
        input int                pd
    );
        logic [2*MAX_PD-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_PD; i++) begin
            if (i < pd) begin
                r[i]      = px[i];
                r[i + pd] = px[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cam_line_buf_sdp.sv
// Simple dual-port line RAM, one write and one registered read port.
// The read register holds its value on cycles with no read issued.
module cam_line_buf_sdp #(
    parameter int DEPTH = 270,
    parameter int WIDTH = 48,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cam_scale_up_2x_nn.sv
// Nearest-neighbour 2x upscaler for the 2PPC RGB path.
// Row A streams and stores a line; row B replays it from line RAM.
module cam_scale_up_2x_nn
    import cam_pkg::*;
#(
    parameter int P_DEPTH         = 8,
    parameter int IN_FRAME_WIDTH  = 540,
    parameter int IN_FRAME_HEIGHT = 540
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*P_DEPTH-1:0] in_red,
    input  logic [2*P_DEPTH-1:0] in_green,
    input  logic [2*P_DEPTH-1:0] in_blue,
    input  logic                 in_sof,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*P_DEPTH-1:0] out_red,
    output logic [2*P_DEPTH-1:0] out_green,
    output logic [2*P_DEPTH-1:0] out_blue,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [10:0]          out_x,
    output logic [11:0]          out_y
);

    localparam int IN_WORDS = IN_FRAME_WIDTH / PPC;
    localparam int HW       = PPC * P_DEPTH;
    localparam int WW       = 3 * HW;
    localparam int AW       = $clog2(IN_WORDS + 1);
    localparam int RAW      = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam logic [10:0] XLAST = 11'(IN_FRAME_WIDTH - 1);
    localparam logic [11:0] YLAST = 12'(2 * IN_FRAME_HEIGHT - 1);

    function automatic logic [WW-1:0] expand(
        input logic [WW-1:0] w,
        input logic          hi
    );
        logic [WW-1:0]      r;
        logic [P_DEPTH-1:0] px;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            px = hi ? w[c*HW+P_DEPTH +: P_DEPTH] : w[c*HW +: P_DEPTH];
            r[c*HW +: HW] = HW'(dup_px(MAX_PD'(px), P_DEPTH));
        end
        return r;
    endfunction

    row_state_e    state, state_n;
    logic          phase, phase_n;
    logic          hold_full, hold_full_n;
    logic [WW-1:0] hold, hold_n;
    logic [AW-1:0] wr_addr, wr_addr_n;
    logic [AW-1:0] rd_addr, rd_addr_n;
    logic [WW-1:0] out_word, out_word_n;
    logic          out_valid_n;
    logic [10:0]   out_x_n, nx, nx_n, pos_x;
    logic [11:0]   out_y_n, ny, ny_n, pos_y;

    logic          load, acc, resync, last_in, ld;
    logic [WW-1:0] ld_word, in_word, rd_data;
    logic          wr_en, rd_en;
    logic [AW-1:0] wr_ram_addr, rd_ram_addr;

    assign in_word   = {in_blue, in_green, in_red};
    assign out_red   = out_word[HW-1:0];
    assign out_green = out_word[2*HW-1:HW];
    assign out_blue  = out_word[3*HW-1:2*HW];

    cam_line_buf_sdp #(
        .DEPTH (IN_WORDS),
        .WIDTH (WW),
        .AW    (RAW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ram_addr[RAW-1:0]),
        .wr_data (in_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ram_addr[RAW-1:0]),
        .rd_data (rd_data)
    );

    always_comb begin
        state_n     = state;
        phase_n     = phase;
        hold_full_n = hold_full;
        hold_n      = hold;
        wr_addr_n   = wr_addr;
        rd_addr_n   = rd_addr;
        out_word_n  = out_word;
        out_valid_n = out_valid;
        out_x_n     = out_x;
        out_y_n     = out_y;
        nx_n        = nx;
        ny_n        = ny;
        ld          = 1'b0;
        ld_word     = '0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        wr_ram_addr = wr_addr;
        rd_ram_addr = '0;

        load     = ~out_valid | out_ready;
        last_in  = (wr_addr == AW'(IN_WORDS));
        in_ready = rst_n & (state == ROW_A) & ~last_in
                 & (~hold_full | (load & phase));
        acc      = in_valid & in_ready;
        resync   = acc & in_sof & ((wr_addr != '0) | (ny != '0));

        unique case (state)
            ROW_A: begin
                if (acc) begin
                    wr_en       = 1'b1;
                    wr_ram_addr = resync ? '0 : wr_addr;
                    wr_addr_n   = resync ? AW'(1) : wr_addr + AW'(1);
                    hold_n      = in_word;
                    hold_full_n = 1'b1;
                end
                // A resync drops any pending high copy of the old line.
                if (acc & (resync | ~hold_full)) begin
                    phase_n = load;
                    if (load) begin
                        ld      = 1'b1;
                        ld_word = expand(in_word, 1'b0);
                    end
                end else if (load & hold_full & ~phase) begin
                    ld      = 1'b1;
                    ld_word = expand(hold, 1'b0);
                    phase_n = 1'b1;
                end else if (load & hold_full & phase) begin
                    ld      = 1'b1;
                    ld_word = expand(hold, 1'b1);
                    phase_n = 1'b0;
                    if (!acc) hold_full_n = 1'b0;
                    if (last_in) begin
                        state_n     = ROW_B;
                        rd_en       = 1'b1;
                        rd_ram_addr = '0;
                        rd_addr_n   = '0;
                    end
                end
            end
            ROW_B: begin
                // Keep the RAM word so the next read can overlap the high copy.
                if (load & ~phase) begin
                    ld        = 1'b1;
                    ld_word   = expand(rd_data, 1'b0);
                    hold_n    = rd_data;
                    phase_n   = 1'b1;
                    rd_addr_n = rd_addr + AW'(1);
                    if (rd_addr != AW'(IN_WORDS - 1)) begin
                        rd_en       = 1'b1;
                        rd_ram_addr = rd_addr + AW'(1);
                    end
                end else if (load & phase) begin
                    ld      = 1'b1;
                    ld_word = expand(hold, 1'b1);
                    phase_n = 1'b0;
                    if (rd_addr == AW'(IN_WORDS)) begin
                        state_n   = ROW_A;
                        wr_addr_n = '0;
                        rd_addr_n = '0;
                    end
                end
            end
        endcase

        pos_x = resync ? '0 : nx;
        pos_y = resync ? '0 : ny;
        if (resync) begin
            nx_n = '0;
            ny_n = '0;
        end
        if (ld) begin
            out_word_n = ld_word;
            out_x_n    = pos_x;
            out_y_n    = pos_y;
            if (pos_x == XLAST) begin
                nx_n = '0;
                ny_n = (pos_y == YLAST) ? '0 : pos_y + 12'd1;
            end else begin
                nx_n = pos_x + 11'd1;
                ny_n = pos_y;
            end
        end
        if (load) out_valid_n = ld;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ROW_A;
            phase     <= 1'b0;
            hold_full <= 1'b0;
            hold      <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            nx        <= '0;
            ny        <= '0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            hold_full <= hold_full_n;
            hold      <= hold_n;
            wr_addr   <= wr_addr_n;
            rd_addr   <= rd_addr_n;
            out_word  <= out_word_n;
            out_valid <= out_valid_n;
            out_x     <= out_x_n;
            out_y     <= out_y_n;
            nx        <= nx_n;
            ny        <= ny_n;
        end
    end

endmodule

// File: tb/tb_cam_scale_up_2x_nn.sv
// Self-checking bench for cam_scale_up_2x_nn (8x2 input frame).
// Table vectors, random backpressure against a line-level model, resync.
module tb_cam_scale_up_2x_nn;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int NW = W / 2;

    logic        clk, rst_n;
    logic [15:0] in_red, in_green, in_blue;
    logic        in_sof, in_valid, in_ready;
    logic [15:0] out_red, out_green, out_blue;
    logic        out_valid, out_ready;
    logic [10:0] out_x;
    logic [11:0] out_y;

    cam_scale_up_2x_nn #(
        .P_DEPTH         (8),
        .IN_FRAME_WIDTH  (W),
        .IN_FRAME_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_red    (in_red),
        .in_green  (in_green),
        .in_blue   (in_blue),
        .in_sof    (in_sof),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_red   (out_red),
        .out_green (out_green),
        .out_blue  (out_blue),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y)
    );

    typedef struct {
        logic [47:0] px;
        int          x;
        int          y;
        int          t;
        logic        rdy;
    } obs_t;

    typedef struct {
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
        logic [47:0] lo;
        logic [47:0] hi;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic bp    = 1'b0;
    obs_t got[$];
    obs_t exp_q[$];

    logic        prev_stall = 1'b0;
    logic [95:0] prev_snap;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [95:0] a,
                       input logic [95:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, a, e, cyc);
        end
    endtask

    function automatic logic [47:0] dup_word(input logic [47:0] w,
                                             input int hi);
        logic [47:0] r;
        logic [7:0]  p;
        for (int c = 0; c < 3; c++) begin
            p = 8'((w >> (16 * c + 8 * hi)) & 48'hFF);
            r[16*c +: 16] = {p, p};
        end
        return r;
    endfunction

    function automatic logic [47:0] mkw(input logic [15:0] base);
        return {base + 16'h8080, base + 16'h4040, base};
    endfunction

    // Output monitor plus hold-while-stalled check.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold",
                    {24'd0, out_valid, out_blue, out_green, out_red,
                     out_x, out_y},
                    prev_snap);
            prev_stall = out_valid & ~out_ready;
            prev_snap  = {24'd0, out_valid, out_blue, out_green, out_red,
                          out_x, out_y};
            if (out_valid && out_ready)
                got.push_back('{px: {out_blue, out_green, out_red},
                                x: int'(out_x), y: int'(out_y),
                                t: cyc, rdy: in_ready});
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send(input logic [47:0] w, input logic sof);
        bit done;
        done     = 0;
        in_red   = w[15:0];
        in_green = w[31:16];
        in_blue  = w[47:32];
        in_sof   = sof;
        in_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no in_ready expected accept");
        end
    endtask

    task automatic wait_n(input int n, input string nm);
        for (int i = 0; i < 2000 && got.size() < n; i++) @(negedge clk);
        if (got.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %0d words expected %0d",
                     nm, got.size(), n);
        end
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        exp_q.delete();
    endtask

    vec_t        tbl[NW];
    logic [47:0] lines[2*H][NW];
    logic [47:0] sw;
    int          idx;

    initial begin
        tbl[0] = '{16'h1110, 16'h3130, 16'h5150,
                   48'h5050_3030_1010, 48'h5151_3131_1111};
        tbl[1] = '{16'h1312, 16'h3332, 16'h5352,
                   48'h5252_3232_1212, 48'h5353_3333_1313};
        tbl[2] = '{16'h1514, 16'h3534, 16'h5554,
                   48'h5454_3434_1414, 48'h5555_3535_1515};
        tbl[3] = '{16'h1716, 16'h3736, 16'h5756,
                   48'h5656_3636_1616, 48'h5757_3737_1717};

        // Reset state
        idle();
        in_red = '0; in_green = '0; in_blue = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 96'(out_valid), 96'd0);
        chk("rst_in_ready",  96'(in_ready),  96'd0);
        chk("rst_out_x",     96'(out_x),     96'd0);
        chk("rst_out_y",     96'(out_y),     96'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();

        // Basic expansion and full-rate timing
        for (int k = 0; k < NW; k++)
            send({tbl[k].b, tbl[k].g, tbl[k].r}, k == 0);
        idle();
        wait_n(16, "basic_drain");
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < NW; k++)
                for (int h = 0; h < 2; h++) begin
                    idx = c * 8 + k * 2 + h;
                    chk("basic_px", 96'(got[idx].px),
                        96'(h ? tbl[k].hi : tbl[k].lo));
                    chk("basic_pos", {32'd0, got[idx].x, got[idx].y},
                        {32'd0, 2 * k + h, c});
                    if (c == 1 && idx < 15)
                        chk("row_b_in_ready", 96'(got[idx].rdy), 96'd0);
                end
        chk("row_a_rate", 96'(got[7].t - got[0].t), 96'd7);
        n_cmp++;
        if (got[15].t - got[8].t > 8) begin
            n_bad++;
            $display("FAIL row_b_rate: got %0d cycles expected <= 9",
                     got[15].t - got[8].t + 1);
        end

        // Reset mid-line
        send(mkw(16'h0F0E), 1'b1);
        send(mkw(16'h0D0C), 1'b0);
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 96'(out_valid), 96'd0);
        do_reset();

        // Two random frames under 50% backpressure
        bp = 1'b1;
        for (int l = 0; l < 2 * H; l++)
            for (int k = 0; k < NW; k++)
                lines[l][k] = {16'($urandom), 16'($urandom), 16'($urandom)};
        for (int l = 0; l < 2 * H; l++)
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < NW; k++)
                    for (int h = 0; h < 2; h++)
                        exp_q.push_back('{px: dup_word(lines[l][k], h),
                                          x: 2 * k + h,
                                          y: (2 * l + c) % (2 * H),
                                          t: 0, rdy: 1'b0});
        for (int l = 0; l < 2 * H; l++)
            for (int k = 0; k < NW; k++)
                send(lines[l][k], (l % H == 0) && (k == 0));
        idle();
        wait_n(exp_q.size(), "rand_drain");
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("rand_px", 96'(got[i].px), 96'(exp_q[i].px));
            chk("rand_pos", {32'd0, got[i].x, got[i].y},
                {32'd0, exp_q[i].x, exp_q[i].y});
        end
        bp = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Resync on word 2 of input line 1
        do_reset();
        for (int k = 0; k < NW; k++)
            send(mkw(16'(16'h0100 + k * 16'h0202)), k == 0);
        send(mkw(16'h0908), 1'b0);
        send(mkw(16'h0B0A), 1'b0);
        lines[0][0] = mkw(16'h2120);
        lines[0][1] = mkw(16'h2322);
        lines[0][2] = mkw(16'h2524);
        lines[0][3] = mkw(16'h2726);
        send(lines[0][0], 1'b1);
        for (int k = 1; k < NW; k++) send(lines[0][k], 1'b0);
        idle();
        repeat (100) @(negedge clk);
        sw  = dup_word(lines[0][0], 0);
        idx = -1;
        for (int i = 0; i < got.size() && idx < 0; i++)
            if (got[i].px == sw) idx = i;
        n_cmp++;
        if (idx < 0 || idx + 16 > got.size()) begin
            n_bad++;
            $display("FAIL resync_found: got index %0d of %0d expected run",
                     idx, got.size());
        end else begin
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < NW; k++)
                    for (int h = 0; h < 2; h++) begin
                        chk("resync_px", 96'(got[idx].px),
                            96'(dup_word(lines[0][k], h)));
                        chk("resync_pos", {32'd0, got[idx].x, got[idx].y},
                            {32'd0, 2 * k + h, c});
                        idx++;
                    end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cam_scale_up_2x_nn.md
Name: cam_scale_up_2x_nn

Overview:
Nearest-neighbour 2x upscaler for the 2-pixel-per-clock (2PPC) RGB camera/display path; the inverse of the 2x NN downscaler.
- Horizontal: each input pixel is emitted twice.
- Vertical: each input line is emitted twice; the second copy is replayed from an internal line buffer.
- Output rate is 4x the input word rate, so both sides use valid/ready handshakes. The block sits between the NN-output/frame-buffer reader and the display pipeline.

Parameters:
- P_DEPTH, 8, bits per colour component per pixel.
- IN_FRAME_WIDTH, 540, input pixels per line; must be even. IN_WORDS = IN_FRAME_WIDTH/2.
- IN_FRAME_HEIGHT, 540, input lines per frame.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- in_red/in_green/in_blue  in  2*P_DEPTH each  2PPC input word; [P_DEPTH-1:0] = even (earlier) pixel p0, upper half = odd pixel p1.
- in_sof  in  1  qualifies the first word of a frame.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts the input word this cycle.
- out_red/out_green/out_blue  out  2*P_DEPTH each  2PPC output word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_x  out  11  output word index within the line, 0..IN_FRAME_WIDTH-1.
- out_y  out  12  output line index, 0..2*IN_FRAME_HEIGHT-1.

Behaviour:
- Reset: out_valid=0; out_* colour=0; out_x=0; out_y=0; in_ready=0; state=ROW_A; phase=0; wr/rd addr=0. in_ready may assert from the first cycle after reset release.
- Handshake: a transfer occurs on valid&ready. Output registers hold stable while out_valid&~out_ready. out_valid never drops without a transfer.
- Expansion: input word {p1,p0} produces two output words, low copy {p0,p0} then high copy {p1,p1}.
- State ROW_A (first copy of a line):
  - in_ready = hold register empty, or the high copy is being loaded to output this cycle.
  - Accepted word is stored in the hold register and written to line RAM at wr_addr; wr_addr increments.
  - The low copy loads into the output register the same cycle, or on the next output slot.
  - Latency: out_valid rises 1 cycle after the accepting cycle when the output is free.
  - Once the high copy of word IN_WORDS-1 is loaded, go to ROW_B with in_ready=0.
- State ROW_B (replay):
  - Line RAM read latency is 1 cycle. Read of word k+1 is issued when the low copy of word k loads to output. RAM output holds while no read is issued.
  - Sustained throughput is 1 output word/cycle when out_ready=1; one bubble is permitted only at ROW_B entry.
  - After the high copy of word IN_WORDS-1 loads, return to ROW_A and clear wr/rd addr.
- in_ready=0 throughout ROW_B. The replayed line never reads a location being written.
- Counters:
  - out_x increments per output transfer and wraps at IN_FRAME_WIDTH-1.
  - out_y increments on out_x wrap and wraps at 2*IN_FRAME_HEIGHT-1.
  - out_x/out_y describe the word currently on out_*.
- in_sof resync: in_sof accepted while wr_addr!=0 or out_y!=0 discards the partial line and drains/clears pending output. Sequence: pending high copy is dropped, state=ROW_A, wr_addr=0, then the word is processed as word 0 with out_y=0, out_x=0. In-flight out_valid is not withdrawn; that transfer completes first.
- Simultaneous: ROW_A accept and output high-copy load in the same cycle is legal and required for full rate.
- Reset mid-line: all state returns to reset values on the next clock; line RAM contents are don't-care.

Decomposition:
- Shared package (cam_pkg): state encoding ROW_A/ROW_B, 2PPC word-width constant, dup-pixel function (replicate half-word).
- Sub-module cam_line_buf_sdp: simple dual-port RAM, depth IN_WORDS, width 6*P_DEPTH, registered read with hold-on-no-read. This is the inferred block RAM.

Test Plan:
- Reset: IN_FRAME_WIDTH=8, IN_FRAME_HEIGHT=2, out_ready=1. Assert rst_n=0 for 3 cycles -> out_valid=0, in_ready=0, out_x=0, out_y=0.
- Basic expansion: input words red {0x11,0x10},{0x13,0x12},{0x15,0x14},{0x17,0x16}. Expected row 0 out_red = 0x1010,0x1111,0x1212,0x1313,0x1414,0x1515,0x1616,0x1717. Row 1 identical with out_y=1. in_ready=0 during row 1.
- Backpressure: out_ready toggled randomly at 50% -> identical output sequence, no drops or duplicates, output stable while stalled.
- Full throughput: in_valid=1, out_ready=1 -> ROW_A sustains 8 out words in 8 cycles; ROW_B at most 9 cycles.
- Frame wrap: 2 full frames -> out_y sequence 0,1,2,3,0; out_x wraps at 7.
- Resync: in_sof asserted on input word 2 of line 1 -> next outputs restart at out_x=0, out_y=0 with that word's low copy.
